mcycle_seq: RTL and testbench
=============================

# mcycle_seq

Machine-cycle and T-state sequencer for the 8085 core. It consumes the decoded instruction info vector (`chk_inst`) from the ALU/register block and produces that block's register and latch enables (`enb_code`, `enb_data`, `enb_rreg`, `enb_wreg`). It also generates the external bus strobes and status. The block sits between the ALU/register block and the bus interface, and owns all instruction timing.

## Interface

Parameters:
- `INSTSIZE`, 13: width of `chk_inst`.
- `INST_GO6`, 0: bit index; opcode needs T5/T6 in M1.
- `INST_DAD`, 1: bit index; DAD (M2/M3 are internal, no bus).
- `INST_HLT`, 2: bit index; halt.
- `INST_DIO`, 3: bit index; IN/OUT (M3 is an I/O cycle).
- `INST_CYL`/`INST_CYH`, 4/7: extra-cycle thermometer `cycgo` (0000, 0001, 0011, 0111, 1111).
- `INST_RWL`/`INST_RWH`, 8/11: `cycrw`; bit k=1 makes M(k+2) a write cycle.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `chk_inst`  in  INSTSIZE  decoded info for the opcode currently in the instruction register.
- `ready`  in  1  bus ready; 0 requests wait states.
- `t_state`  out  3  1–6 = T1–T6, 7 = TW, 0 = THALT.
- `m_cycle`  out  3  1–5 = M1–M5.
- `ale`  out  1  address latch enable.
- `rd_n`  out  1  read strobe, active-low.
- `wr_n`  out  1  write strobe, active-low.
- `io_m`  out  1  1 = I/O space.
- `s1`, `s0`  out  1 each  bus status.
- `enb_code`  out  1  latch opcode into the instruction register.
- `enb_data`  out  1  latch data into the temp register.
- `enb_rreg`  out  1  register-file read enable.
- `enb_wreg`  out  1  register-file write enable.
- `halted`  out  1  core is in the halt state.

## Operation

- State is (`m_cycle`, `t_state`) plus a 1-bit `wb_pend` flag. All outputs are combinational decodes of the state.
- While `rst`=1, every output except `t_state`/`m_cycle` is forced inactive: strobes high, enables 0, `ale` 0, `halted` 0, `s1`/`s0`/`io_m` 0.
- On the edge with `rst`=1: state becomes M1/T1 and `wb_pend` becomes 0.
- M1 (opcode fetch): T1 → T2 → [TW…] → T3 → T4 → [T5 → T6].
  - `s1`/`s0` = 11.
  - `ale`=1 in T1.
  - `rd_n`=0 in T2, TW and T3.
  - `enb_code`=1 in T3 only.
  - T5/T6 occur only if `chk_inst[INST_GO6]`=1 at T4.
- End of M1 (at T4 if GO6=0, otherwise at T6):
  - HLT=1 → THALT, and `cycgo` is ignored.
  - Else if `cycgo[0]`=1 → M2/T1.
  - Else → M1/T1.
- Mn, n=2..5: T1 → T2 → [TW…] → T3.
  - Write cycle when `cycrw[n-2]`=1, otherwise read cycle.
  - Read: `s1`/`s0` = 10; `rd_n`=0 in T2/TW/T3; `enb_data`=1 in T3.
  - Write: `s1`/`s0` = 01; `wr_n`=0 in T2/TW/T3.
  - `ale`=1 in T1.
  - `io_m`=1 during M3 when DIO=1.
  - When DAD=1, M2 and M3 keep `ale`=0, both strobes high, `enb_data`=0, `s1`/`s0`=00.
  - After T3: if n<5 and `cycgo[n-1]`=1 → M(n+1)/T1; else → M1/T1.
- Register write-back, single-cycle opcode (`cycgo`=0, HLT=0): `enb_rreg`=`enb_wreg`=1 in T4 of M1.
- Register write-back, multi-cycle opcode whose last cycle is a read: set `wb_pend` when leaving that cycle. In the following M1, `enb_rreg`=`enb_wreg`=1 during T2, then `wb_pend` clears. The old opcode is still held because `enb_code` fires later, in T3.
- Multi-cycle opcode whose last cycle is a write, or DAD: no write-back pulse.
- THALT: `halted`=1, `s1`/`s0`=00, all strobes and enables inactive. Only `rst` exits this state.

## Timing

- `chk_inst` must be stable from T4 of M1 until the next `enb_code`. The block samples it only at the M1 exit decision and in Mn.
- `ready` is sampled at the edge ending T2 and each TW:
  - 0 → TW, or stay in TW.
  - 1 → T3.
- Minimum instruction length: 4 clocks. Maximum without waits: 6 + 4×3 = 18 clocks.
- Reset mid-cycle aborts the cycle immediately. No partial strobe persists past the reset edge.
- Enables are single-cycle pulses. They are never asserted in two consecutive clocks, except `enb_rreg`/`enb_wreg`, which are asserted together.

## Configuration

- `MCYCLE_WAIT_EN` defined: TW is inserted as specified above.
- `MCYCLE_WAIT_EN` undefined: `ready` is ignored, T2 always advances to T3, and TW is unreachable (`t_state`=7 never occurs).

## Test plan

- Reset: hold `rst` for 2 clocks with `ready`=1.
  - Next cycle: `t_state`=1, `m_cycle`=1, `halted`=0.
  - `ale`=1 in the first cycle after reset is released.
- MOV B,C: `chk_inst`=0x0000.
  - Sequence T1, T2, T3, T4, then T1.
  - `enb_code` in T3.
  - `enb_wreg`=`enb_rreg`=1 in T4 only.
- INX: GO6=1, `cycgo`=0 → M1 lasts 6 clocks; `enb_wreg` in T4; next T1 follows T6.
- MVI M: `cycgo`=0011, `cycrw`=0010 → M1 (4 clocks), M2 read with `enb_data` in T3, M3 write with `wr_n`=0 in T2–T3; no write-back pulse; total 10 clocks.
- Wait states with `MCYCLE_WAIT_EN` defined: `ready`=0 for 2 edges during M1 T2.
  - Two TW states are inserted.
  - `rd_n` stays 0 throughout.
  - Without the macro, no TW occurs.
- HLT: HLT=1, `cycgo`=0001 → after M1 T4, `t_state`=0 and `halted`=1 indefinitely. Asserting `rst` returns the block to M1/T1.

Source files
------------

// File: rtl/mcycle_seq.sv
// 8085 machine-cycle / T-state sequencer: owns instruction timing, bus strobes and register enables.
// Optional wait states: define MCYCLE_WAIT_EN to honour `ready` with TW insertion.
module mcycle_seq #(
  parameter int INSTSIZE = 13,
  parameter int INST_GO6 = 0,
  parameter int INST_DAD = 1,
  parameter int INST_HLT = 2,
  parameter int INST_DIO = 3,
  parameter int INST_CYL = 4,
  parameter int INST_CYH = 7,
  parameter int INST_RWL = 8,
  parameter int INST_RWH = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTSIZE-1:0] chk_inst,
  input  logic                ready,
  output logic [2:0]          t_state,
  output logic [2:0]          m_cycle,
  output logic                ale,
  output logic                rd_n,
  output logic                wr_n,
  output logic                io_m,
  output logic                s1,
  output logic                s0,
  output logic                enb_code,
  output logic                enb_data,
  output logic                enb_rreg,
  output logic                enb_wreg,
  output logic                halted
);

  localparam logic [2:0] T_HALT = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
                         T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T_WAIT = 3'd7;
  localparam logic [2:0] M1 = 3'd1, M2 = 3'd2, M3 = 3'd3, M4 = 3'd4, M5 = 3'd5;

  logic [2:0] t_state_r, m_cycle_r, t_next_s, m_next_s;
  logic       wb_pend_r, wb_next_s;
  logic       go6_s, dad_s, hlt_s, dio_s;
  logic [3:0] cycgo_s, cycrw_s;
  logic [2:0] end_t_s, end_m_s;
  logic       more_s, wr_s, dad_idle_s, strobe_s, ready_go_s;
  logic       unused_s;

  assign go6_s   = chk_inst[INST_GO6];
  assign dad_s   = chk_inst[INST_DAD];
  assign hlt_s   = chk_inst[INST_HLT];
  assign dio_s   = chk_inst[INST_DIO];
  assign cycgo_s = chk_inst[INST_CYH:INST_CYL];
  assign cycrw_s = chk_inst[INST_RWH:INST_RWL];

`ifdef MCYCLE_WAIT_EN
  assign ready_go_s = ready;
  assign unused_s   = ^chk_inst;
`else
  assign ready_go_s = 1'b1;
  assign unused_s   = ^{chk_inst, ready};
`endif

  // Where M1 goes when it finishes: halt wins over any extra cycles
  assign end_t_s = hlt_s ? T_HALT : T1;
  assign end_m_s = (!hlt_s && cycgo_s[0]) ? M2 : M1;

  assign dad_idle_s = dad_s && ((m_cycle_r == M2) || (m_cycle_r == M3));
  assign strobe_s   = (t_state_r == T2) || (t_state_r == T3) || (t_state_r == T_WAIT);

  // Per-Mn decode: direction of this cycle and whether another cycle follows
  always_comb begin
    more_s = 1'b0;
    wr_s   = 1'b0;
    case (m_cycle_r)
      M2:      begin more_s = cycgo_s[1]; wr_s = cycrw_s[0]; end
      M3:      begin more_s = cycgo_s[2]; wr_s = cycrw_s[1]; end
      M4:      begin more_s = cycgo_s[3]; wr_s = cycrw_s[2]; end
      M5:      begin more_s = 1'b0;       wr_s = cycrw_s[3]; end
      default: begin more_s = 1'b0;       wr_s = 1'b0;       end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      t_state_r <= T1;
      m_cycle_r <= M1;
      wb_pend_r <= 1'b0;
    end else begin
      t_state_r <= t_next_s;
      m_cycle_r <= m_next_s;
      wb_pend_r <= wb_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    t_next_s  = t_state_r;
    m_next_s  = m_cycle_r;
    wb_next_s = wb_pend_r;
    case (t_state_r)
      T_HALT: t_next_s = T_HALT;
      T1:     t_next_s = T2;
      T2: begin
        // The pending write-back is consumed during M1 T2
        if (m_cycle_r == M1) wb_next_s = 1'b0;
        else                 wb_next_s = wb_pend_r;
        if (ready_go_s) t_next_s = T3;
        else            t_next_s = T_WAIT;
      end
      T_WAIT: begin
        if (ready_go_s) t_next_s = T3;
        else            t_next_s = T_WAIT;
      end
      T3: begin
        if (m_cycle_r == M1) begin
          t_next_s = T4;
        end else if (more_s) begin
          t_next_s = T1;
          m_next_s = m_cycle_r + 3'd1;
        end else begin
          t_next_s  = T1;
          m_next_s  = M1;
          wb_next_s = !wr_s && !dad_s;
        end
      end
      T4: begin
        if (go6_s) begin
          t_next_s = T5;
        end else begin
          t_next_s = end_t_s;
          m_next_s = end_m_s;
        end
      end
      T5: t_next_s = T6;
      T6: begin
        t_next_s = end_t_s;
        m_next_s = end_m_s;
      end
      default: begin
        t_next_s = T1;
        m_next_s = M1;
      end
    endcase
  end

  // Output decode of the current state
  always_comb begin
    ale      = 1'b0;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    io_m     = 1'b0;
    s1       = 1'b0;
    s0       = 1'b0;
    enb_code = 1'b0;
    enb_data = 1'b0;
    enb_rreg = 1'b0;
    enb_wreg = 1'b0;
    halted   = 1'b0;
    if (rst) begin
      halted = 1'b0;
    end else if (t_state_r == T_HALT) begin
      halted = 1'b1;
    end else if (m_cycle_r == M1) begin
      s1       = 1'b1;
      s0       = 1'b1;
      ale      = (t_state_r == T1);
      rd_n     = !strobe_s;
      enb_code = (t_state_r == T3);
      enb_rreg = ((t_state_r == T4) && (cycgo_s == 4'b0000) && !hlt_s) ||
                 ((t_state_r == T2) && wb_pend_r);
      enb_wreg = enb_rreg;
    end else if (dad_idle_s) begin
      s1 = 1'b0;
      s0 = 1'b0;
    end else begin
      ale  = (t_state_r == T1);
      io_m = (m_cycle_r == M3) && dio_s;
      if (wr_s) begin
        s0   = 1'b1;
        wr_n = !strobe_s;
      end else begin
        s1       = 1'b1;
        rd_n     = !strobe_s;
        enb_data = (t_state_r == T3);
      end
    end
  end

  assign t_state = t_state_r;
  assign m_cycle = m_cycle_r;

endmodule

// File: tb/tb_mcycle_seq.sv
// Scoreboard bench for mcycle_seq: each driven cycle queues its hand-computed expected outputs,
// and a negedge monitor pops and compares the full output vector.
module tb_mcycle_seq;

  logic        clk;
  logic        rst;
  logic [12:0] chk_inst;
  logic        ready;
  logic [2:0]  t_state, m_cycle;
  logic        ale, rd_n, wr_n, io_m, s1, s0;
  logic        enb_code, enb_data, enb_rreg, enb_wreg, halted;

  mcycle_seq dut (
    .clk(clk), .rst(rst), .chk_inst(chk_inst), .ready(ready),
    .t_state(t_state), .m_cycle(m_cycle), .ale(ale), .rd_n(rd_n), .wr_n(wr_n),
    .io_m(io_m), .s1(s1), .s0(s0), .enb_code(enb_code), .enb_data(enb_data),
    .enb_rreg(enb_rreg), .enb_wreg(enb_wreg), .halted(halted)
  );

  // Output field order: ale rd_n wr_n io_m s1 s0 code data rreg wreg halted
  localparam logic [10:0] IDLE  = 11'b0_1_1_0_00_0_0_0_0_0;
  localparam logic [10:0] F_T1  = 11'b1_1_1_0_11_0_0_0_0_0;
  localparam logic [10:0] F_RD  = 11'b0_0_1_0_11_0_0_0_0_0;
  localparam logic [10:0] F_T3  = 11'b0_0_1_0_11_1_0_0_0_0;
  localparam logic [10:0] F_T4  = 11'b0_1_1_0_11_0_0_0_0_0;
  localparam logic [10:0] F_WB4 = 11'b0_1_1_0_11_0_0_1_1_0;
  localparam logic [10:0] F_WB2 = 11'b0_0_1_0_11_0_0_1_1_0;
  localparam logic [10:0] R_T1  = 11'b1_1_1_0_10_0_0_0_0_0;
  localparam logic [10:0] R_RD  = 11'b0_0_1_0_10_0_0_0_0_0;
  localparam logic [10:0] R_T3  = 11'b0_0_1_0_10_0_1_0_0_0;
  localparam logic [10:0] W_T1  = 11'b1_1_1_0_01_0_0_0_0_0;
  localparam logic [10:0] W_ST  = 11'b0_1_0_0_01_0_0_0_0_0;
  localparam logic [10:0] IO_T1 = 11'b1_1_1_1_10_0_0_0_0_0;
  localparam logic [10:0] IO_RD = 11'b0_0_1_1_10_0_0_0_0_0;
  localparam logic [10:0] IO_T3 = 11'b0_0_1_1_10_0_1_0_0_0;
  localparam logic [10:0] HALT  = 11'b0_1_1_0_00_0_0_0_0_1;

  typedef struct {
    logic [16:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input logic r, input logic rdy, input logic [12:0] ci,
                     input logic [2:0] t, input logic [2:0] m, input logic [10:0] o,
                     input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    ready    = rdy;
    chk_inst = ci;
    e.v      = {t, m, o};
    e.tag    = tag;
    sb.push_back(e);
  endtask

  task automatic chk_now(input logic ok, input string tag);
    checks++;
    if (ok === 1'b1) passed++;
    else $display("FAIL %s: t=%0d m=%0d ale=%b rd_n=%b halted=%b",
                  tag, t_state, m_cycle, ale, rd_n, halted);
  endtask

  // Fetch M1 without write-back at T4 (multi-cycle or halt opcodes)
  task automatic m1_plain(input logic [12:0] ci, input logic [10:0] t2o, input string tag);
    cyc(1'b0, 1'b1, ci, 3'd1, 3'd1, F_T1, {tag, "_t1"});
    cyc(1'b0, 1'b1, ci, 3'd2, 3'd1, t2o,  {tag, "_t2"});
    cyc(1'b0, 1'b1, ci, 3'd3, 3'd1, F_T3, {tag, "_t3"});
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] act;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = {t_state, m_cycle, ale, rd_n, wr_n, io_m, s1, s0,
             enb_code, enb_data, enb_rreg, enb_wreg, halted};
      checks++;
      if (act === e.v) passed++;
      else $display("FAIL %s: got %05h expected %05h", e.tag, act, e.v);
    end
  end

  initial begin
    rst = 1'b1; ready = 1'b1; chk_inst = 13'h000;
    @(posedge clk);
    // Second reset clock: state already M1/T1, outputs forced inactive
    cyc(1'b1, 1'b1, 13'h000, 3'd1, 3'd1, IDLE, "reset");

    // MOV B,C
    cyc(1'b0, 1'b1, 13'h000, 3'd1, 3'd1, F_T1,  "mov_t1");
    @(negedge clk);
    chk_now((t_state == 3'd1) && (m_cycle == 3'd1) && (halted == 1'b0) && (ale == 1'b1),
            "reset_state");
    cyc(1'b0, 1'b1, 13'h000, 3'd2, 3'd1, F_RD,  "mov_t2");
    cyc(1'b0, 1'b1, 13'h000, 3'd3, 3'd1, F_T3,  "mov_t3");
    cyc(1'b0, 1'b1, 13'h000, 3'd4, 3'd1, F_WB4, "mov_t4");

    // INX: six-state M1
    m1_plain(13'h001, F_RD, "inx");
    cyc(1'b0, 1'b1, 13'h001, 3'd4, 3'd1, F_WB4, "inx_t4");
    cyc(1'b0, 1'b1, 13'h001, 3'd5, 3'd1, F_T4,  "inx_t5");
    cyc(1'b0, 1'b1, 13'h001, 3'd6, 3'd1, F_T4,  "inx_t6");

    // MVI M: read M2, write M3, no write-back
    m1_plain(13'h230, F_RD, "mvi");
    cyc(1'b0, 1'b1, 13'h230, 3'd4, 3'd1, F_T4, "mvi_t4");
    cyc(1'b0, 1'b1, 13'h230, 3'd1, 3'd2, R_T1, "mvi_m2t1");
    cyc(1'b0, 1'b1, 13'h230, 3'd2, 3'd2, R_RD, "mvi_m2t2");
    cyc(1'b0, 1'b1, 13'h230, 3'd3, 3'd2, R_T3, "mvi_m2t3");
    cyc(1'b0, 1'b1, 13'h230, 3'd1, 3'd3, W_T1, "mvi_m3t1");
    cyc(1'b0, 1'b1, 13'h230, 3'd2, 3'd3, W_ST, "mvi_m3t2");
    cyc(1'b0, 1'b1, 13'h230, 3'd3, 3'd3, W_ST, "mvi_m3t3");

    // MOV A,M: last cycle is a read, write-back deferred to next M1 T2
    m1_plain(13'h010, F_RD, "movm");
    cyc(1'b0, 1'b1, 13'h010, 3'd4, 3'd1, F_T4, "movm_t4");
    cyc(1'b0, 1'b1, 13'h010, 3'd1, 3'd2, R_T1, "movm_m2t1");
    cyc(1'b0, 1'b1, 13'h010, 3'd2, 3'd2, R_RD, "movm_m2t2");
    cyc(1'b0, 1'b1, 13'h010, 3'd3, 3'd2, R_T3, "movm_m2t3");
    m1_plain(13'h000, F_WB2, "wb");
    cyc(1'b0, 1'b1, 13'h000, 3'd4, 3'd1, F_WB4, "wb_t4");

    // DAD: M2/M3 internal, no bus activity, no write-back
    m1_plain(13'h032, F_RD, "dad");
    cyc(1'b0, 1'b1, 13'h032, 3'd4, 3'd1, F_T4, "dad_t4");
    for (int m = 2; m <= 3; m++)
      for (int t = 1; t <= 3; t++)
        cyc(1'b0, 1'b1, 13'h032, 3'(t), 3'(m), IDLE, "dad_int");

    // IN: M3 is an I/O read
    m1_plain(13'h038, F_RD, "in");
    cyc(1'b0, 1'b1, 13'h038, 3'd4, 3'd1, F_T4,  "in_t4");
    cyc(1'b0, 1'b1, 13'h038, 3'd1, 3'd2, R_T1,  "in_m2t1");
    cyc(1'b0, 1'b1, 13'h038, 3'd2, 3'd2, R_RD,  "in_m2t2");
    cyc(1'b0, 1'b1, 13'h038, 3'd3, 3'd2, R_T3,  "in_m2t3");
    cyc(1'b0, 1'b1, 13'h038, 3'd1, 3'd3, IO_T1, "in_m3t1");
    cyc(1'b0, 1'b1, 13'h038, 3'd2, 3'd3, IO_RD, "in_m3t2");
    cyc(1'b0, 1'b1, 13'h038, 3'd3, 3'd3, IO_T3, "in_m3t3");

    // Longest opcode: GO6 plus M2..M5 (M4/M5 writes), 18 clocks
    m1_plain(13'hCF1, F_WB2, "long");
    cyc(1'b0, 1'b1, 13'hCF1, 3'd4, 3'd1, F_T4, "long_t4");
    cyc(1'b0, 1'b1, 13'hCF1, 3'd5, 3'd1, F_T4, "long_t5");
    cyc(1'b0, 1'b1, 13'hCF1, 3'd6, 3'd1, F_T4, "long_t6");
    for (int m = 2; m <= 3; m++) begin
      cyc(1'b0, 1'b1, 13'hCF1, 3'd1, 3'(m), R_T1, "long_rd_t1");
      cyc(1'b0, 1'b1, 13'hCF1, 3'd2, 3'(m), R_RD, "long_rd_t2");
      cyc(1'b0, 1'b1, 13'hCF1, 3'd3, 3'(m), R_T3, "long_rd_t3");
    end
    for (int m = 4; m <= 5; m++) begin
      cyc(1'b0, 1'b1, 13'hCF1, 3'd1, 3'(m), W_T1, "long_wr_t1");
      cyc(1'b0, 1'b1, 13'hCF1, 3'd2, 3'(m), W_ST, "long_wr_t2");
      cyc(1'b0, 1'b1, 13'hCF1, 3'd3, 3'(m), W_ST, "long_wr_t3");
    end

    // Wait states: ready low for two edges during M1 T2
    cyc(1'b0, 1'b1, 13'h000, 3'd1, 3'd1, F_T1, "wait_t1");
    cyc(1'b0, 1'b0, 13'h000, 3'd2, 3'd1, F_RD, "wait_t2");
`ifdef MCYCLE_WAIT_EN
    cyc(1'b0, 1'b0, 13'h000, 3'd7, 3'd1, F_RD, "wait_tw1");
    cyc(1'b0, 1'b1, 13'h000, 3'd7, 3'd1, F_RD, "wait_tw2");
    cyc(1'b0, 1'b1, 13'h000, 3'd3, 3'd1, F_T3, "wait_t3");
`else
    cyc(1'b0, 1'b0, 13'h000, 3'd3, 3'd1, F_T3, "nowait_t3");
`endif
    @(negedge clk);
    chk_now((t_state == 3'd3) && (m_cycle == 3'd1) && (rd_n == 1'b0), "wait_expired");
    cyc(1'b0, 1'b1, 13'h000, 3'd4, 3'd1, F_WB4, "wait_t4");

    // Reset in the middle of an M2 read aborts it and drops the pending write-back
    m1_plain(13'h010, F_RD, "abort");
    cyc(1'b0, 1'b1, 13'h010, 3'd4, 3'd1, F_T4, "abort_t4");
    cyc(1'b0, 1'b1, 13'h010, 3'd1, 3'd2, R_T1, "abort_m2t1");
    cyc(1'b1, 1'b1, 13'h010, 3'd2, 3'd2, IDLE, "abort_rst");

    // HLT fetched right after the abort
    m1_plain(13'h014, F_RD, "hlt");
    cyc(1'b0, 1'b1, 13'h014, 3'd4, 3'd1, F_T4, "hlt_t4");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 13'h014, 3'd0, 3'd1, HALT, "halt");
    cyc(1'b1, 1'b1, 13'h014, 3'd0, 3'd1, IDLE, "halt_rst");
    cyc(1'b0, 1'b1, 13'h000, 3'd1, 3'd1, F_T1, "post_t1");
    cyc(1'b0, 1'b1, 13'h000, 3'd2, 3'd1, F_RD, "post_t2");

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
